// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
package period_meter_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TIMEOUT
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge detector.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~prev_reg;

endmodule

// File: rtl/period_meter.sv
// Measures the rising-to-rising period of sig_in in clk cycles, with saturation timeout.
// Optional high-time measurement is enabled by defining PERIOD_METER_HIGHTIME_EN.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
`ifdef PERIOD_METER_HIGHTIME_EN
  output logic [WIDTH-1:0] high_time,
`endif
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic level;
  logic rise;

  sync_edge u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (sig_in),
    .level (level),
    .rise  (rise)
  );

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic             valid_reg, valid_next;
  logic             locked_reg, locked_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      period_reg <= '0;
      valid_reg  <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      valid_reg  <= valid_next;
      locked_reg <= locked_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    period_next = period_reg;
    valid_next  = 1'b0;
    locked_next = locked_reg;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = MEASURE;
          cnt_next   = CNT_ONE;
        end
      end
      MEASURE: begin
        // A rise on the saturation cycle still counts as a valid measurement.
        if (rise) begin
          period_next = cnt_reg;
          valid_next  = 1'b1;
          locked_next = 1'b1;
          cnt_next    = CNT_ONE;
        end else if (cnt_reg == CNT_MAX) begin
          state_next  = TIMEOUT;
          locked_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      TIMEOUT: begin
        if (rise) begin
          state_next = MEASURE;
          cnt_next   = CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign period       = period_reg;
  assign period_valid = valid_reg;
  assign locked       = locked_reg;
  assign timeout      = (state_reg == TIMEOUT);

`ifdef PERIOD_METER_HIGHTIME_EN
  logic [WIDTH-1:0] ht_cnt_reg, ht_cnt_next;
  logic [WIDTH-1:0] high_time_reg, high_time_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      ht_cnt_reg    <= '0;
      high_time_reg <= '0;
    end else begin
      ht_cnt_reg    <= ht_cnt_next;
      high_time_reg <= high_time_next;
    end
  end

  // The rise cycle itself has level=1, so a restart begins at one.
  always_comb begin
    ht_cnt_next    = ht_cnt_reg;
    high_time_next = high_time_reg;
    if (rise) begin
      ht_cnt_next = CNT_ONE;
      if (state_reg == MEASURE) high_time_next = ht_cnt_reg;
    end else if (state_reg == MEASURE && level && ht_cnt_reg != CNT_MAX) begin
      ht_cnt_next = ht_cnt_reg + CNT_ONE;
    end
  end

  assign high_time = high_time_reg;
`else
  logic level_unused;
  assign level_unused = level;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: a WIDTH=16 and a WIDTH=4 instance, scoreboard of expected pulses.
module tb_period_meter;

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] h;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16 = 1'b0, sig16 = 1'b0;
  logic [15:0] period16;
  logic        pv16, lk16, to16;
  logic        rst4 = 1'b0, sig4 = 1'b0;
  logic [3:0]  period4;
  logic        pv4, lk4, to4;
`ifdef PERIOD_METER_HIGHTIME_EN
  logic [15:0] ht16;
  logic [3:0]  ht4;
`endif

  period_meter #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .rst          (rst16),
    .sig_in       (sig16),
    .period       (period16),
    .period_valid (pv16),
    .locked       (lk16),
`ifdef PERIOD_METER_HIGHTIME_EN
    .high_time    (ht16),
`endif
    .timeout      (to16)
  );

  period_meter #(.WIDTH(4)) dut4 (
    .clk          (clk),
    .rst          (rst4),
    .sig_in       (sig4),
    .period       (period4),
    .period_valid (pv4),
    .locked       (lk4),
`ifdef PERIOD_METER_HIGHTIME_EN
    .high_time    (ht4),
`endif
    .timeout      (to4)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q16[$];
  exp_t q4[$];

  // One clock; sample just after the edge and retire any pulse against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (pv16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL pulse16_unexpected period=%0d expected no pulse", period16);
      end else begin
        e = q16.pop_front();
        $display("d16 pulse period=%0d expected=%0d", period16, e.p);
        if (period16 !== e.p) begin
          errors++;
          $display("FAIL period16 got=%0d expected=%0d", period16, e.p);
        end
`ifdef PERIOD_METER_HIGHTIME_EN
        checks++;
        if (ht16 !== e.h) begin
          errors++;
          $display("FAIL high_time16 got=%0d expected=%0d", ht16, e.h);
        end
`endif
      end
    end
    if (pv4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL pulse4_unexpected period=%0d expected no pulse", period4);
      end else begin
        e = q4.pop_front();
        $display("d4 pulse period=%0d expected=%0d", period4, e.p);
        if (period4 !== e.p[3:0]) begin
          errors++;
          $display("FAIL period4 got=%0d expected=%0d", period4, e.p);
        end
`ifdef PERIOD_METER_HIGHTIME_EN
        checks++;
        if (ht4 !== e.h[3:0]) begin
          errors++;
          $display("FAIL high_time4 got=%0d expected=%0d", ht4, e.h);
        end
`endif
      end
    end
  endtask

  task automatic set_sig(input bit use4, input logic v);
    if (use4) sig4 = v;
    else sig16 = v;
  endtask

  task automatic wave(input bit use4, input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      set_sig(use4, 1'b1);
      repeat (hi) step();
      set_sig(use4, 1'b0);
      repeat (lo) step();
    end
  endtask

  task automatic push(input bit use4, input int p, input int h, input int n);
    exp_t e;
    e.p = 16'(p);
    e.h = 16'(h);
    for (int i = 0; i < n; i++) begin
      if (use4) q4.push_back(e);
      else q16.push_back(e);
    end
  endtask

  task automatic do_reset(input bit use4);
    set_sig(use4, 1'b0);
    if (use4) rst4 = 1'b1;
    else rst16 = 1'b1;
    repeat (2) step();
    if (use4) rst4 = 1'b0;
    else rst16 = 1'b0;
  endtask

  task automatic test_reset();
    rst16 = 1'b1;
    rst4  = 1'b1;
    repeat (3) step();
    checks++;
    if ({period16, pv16, lk16, to16} !== 19'd0) begin
      errors++;
      $display("FAIL reset16 got=%h expected=0", {period16, pv16, lk16, to16});
    end
    checks++;
    if ({period4, pv4, lk4, to4} !== 7'd0) begin
      errors++;
      $display("FAIL reset4 got=%h expected=0", {period4, pv4, lk4, to4});
    end
`ifdef PERIOD_METER_HIGHTIME_EN
    checks++;
    if (ht16 !== 16'd0 || ht4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_high_time got=%0d/%0d expected=0/0", ht16, ht4);
    end
`endif
    rst16 = 1'b0;
    rst4  = 1'b0;
    $display("reset done");
  endtask

  task automatic test_square();
    do_reset(1'b0);
    push(1'b0, 6, 3, 4);
    wave(1'b0, 3, 3, 5);
    repeat (4) step();
    checks++;
    if (q16.size() != 0) begin
      errors++;
      $display("FAIL square_pulses got_missing=%0d expected=0", q16.size());
    end
    checks++;
    if (lk16 !== 1'b1 || to16 !== 1'b0) begin
      errors++;
      $display("FAIL square_lock got=%b%b expected=10", lk16, to16);
    end
  endtask

  task automatic test_divider();
    do_reset(1'b0);
    push(1'b0, 5, 2, 7);
    wave(1'b0, 2, 3, 8);
    repeat (4) step();
    checks++;
    if (q16.size() != 0 || period16 !== 16'd5) begin
      errors++;
      $display("FAIL divider got_period=%0d missing=%0d expected=5/0", period16, q16.size());
    end
    checks++;
    if (lk16 !== 1'b1 || to16 !== 1'b0) begin
      errors++;
      $display("FAIL divider_lock got=%b%b expected=10", lk16, to16);
    end
  endtask

  task automatic test_timeout();
    int waited;
    do_reset(1'b1);
    push(1'b1, 6, 3, 2);
    wave(1'b1, 3, 3, 3);
    waited = 0;
    while (!to4 && waited < 40) begin
      step();
      waited++;
    end
    checks++;
    if (to4 !== 1'b1 || lk4 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_enter got=%b%b expected=10 after %0d cycles", to4, lk4, waited);
    end
    checks++;
    if (period4 !== 4'd6) begin
      errors++;
      $display("FAIL timeout_hold got=%0d expected=6", period4);
    end
    wave(1'b1, 3, 4, 1);
    checks++;
    if (to4 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_exit got=%b expected=0", to4);
    end
    push(1'b1, 7, 3, 1);
    wave(1'b1, 3, 4, 1);
    checks++;
    if (q4.size() != 0 || period4 !== 4'd7 || lk4 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_relock got_period=%0d locked=%b missing=%0d expected=7/1/0", period4, lk4, q4.size());
    end
  endtask

  task automatic test_rst_mid();
    do_reset(1'b0);
    push(1'b0, 10, 5, 2);
    wave(1'b0, 5, 5, 3);
    rst16 = 1'b1;
    step();
    checks++;
    if ({period16, pv16, lk16, to16} !== 19'd0) begin
      errors++;
      $display("FAIL rst_mid got=%h expected=0", {period16, pv16, lk16, to16});
    end
    step();
    rst16 = 1'b0;
    push(1'b0, 10, 5, 1);
    wave(1'b0, 5, 5, 2);
    repeat (4) step();
    checks++;
    if (q16.size() != 0 || period16 !== 16'd10) begin
      errors++;
      $display("FAIL rst_mid_after got_period=%0d missing=%0d expected=10/0", period16, q16.size());
    end
  endtask

  task automatic test_saturate();
    do_reset(1'b1);
    push(1'b1, 15, 3, 1);
    wave(1'b1, 3, 12, 1);
    wave(1'b1, 3, 2, 1);
    checks++;
    if (q4.size() != 0 || to4 !== 1'b0 || lk4 !== 1'b1) begin
      errors++;
      $display("FAIL saturate got_timeout=%b locked=%b missing=%0d expected=0/1/0", to4, lk4, q4.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    push(1'b0, 2, 1, 7);
    wave(1'b0, 1, 1, 8);
    repeat (4) step();
    checks++;
    if (q16.size() != 0 || period16 !== 16'd2) begin
      errors++;
      $display("FAIL back_to_back got_period=%0d missing=%0d expected=2/0", period16, q16.size());
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_divider();
    test_timeout();
    test_rst_mid();
    test_saturate();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
